dpram_arbiter: RTL and testbench

Round-robin arbiter that shares the two ports of the 64x8 dual-port RAM (`dpram`) between NUM_REQ requesters. Each cycle it grants up to two non-conflicting requests, one per RAM port. It drives the RAM's valid/ready command interface from registered port slots and routes read data back to the owning requester. It sits between the requester fabric and `dpram`, and is the only master of both RAM ports.

---
 rtl/dpram_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dpram_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter that shares both ports of a 64x8 dual-port RAM among NUM_REQ requesters.
// Define DPRAM_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.
module dpram_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [DATA_W-1:0]         rsp_data_b,
    output logic                      valid_a,
    output logic                      valid_b,
    output logic                      we_a,
    output logic                      we_b,
    output logic [ADDR_W-1:0]         addr_a,
    output logic [ADDR_W-1:0]         addr_b,
    output logic [DATA_W-1:0]         data_a,
    output logic [DATA_W-1:0]         data_b,
    input  logic                      ready_a,
    input  logic                      ready_b,
    input  logic [DATA_W-1:0]         q_a,
    input  logic [DATA_W-1:0]         q_b
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_PEND  = 1'b1
    } slot_state_t;

    slot_state_t        r_state_a, r_state_b, w_state_a_nxt, w_state_b_nxt;
    logic               r_we_a, r_we_b;
    logic [ADDR_W-1:0]  r_addr_a, r_addr_b;
    logic [DATA_W-1:0]  r_data_a, r_data_b;
    logic [IDX_W-1:0]   r_tag_a, r_tag_b;
    logic               r_ret_a, r_ret_b;
    logic [NUM_REQ-1:0] r_rsp_valid;

    logic               w_w0_found, w_w1_found;
    logic [IDX_W-1:0]   w_w0_idx, w_w1_idx, w_idx, w_start;
    logic               w_slot_free, w_grant_a, w_grant_b;
    logic               w_acc_rd_a, w_acc_rd_b;
    logic [NUM_REQ-1:0] w_rsp_nxt;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        else              s = s;
        return IDX_W'(s);
    endfunction

    function automatic logic conflict(input logic [ADDR_W-1:0] a0, input logic we0,
                                      input logic [ADDR_W-1:0] a1, input logic we1);
        return (a0 == a1) && (we0 || we1);
    endfunction

`ifdef DPRAM_ARB_FIXED_PRIO_EN
    assign w_start = {IDX_W{1'b0}};
`else
    logic [IDX_W-1:0] r_rr_ptr;

    // Round-robin pointer: one past the last requester granted this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_rr_ptr <= {IDX_W{1'b0}};
        else if (w_grant_a)
            r_rr_ptr <= w_grant_b ? wrap_idx(w_w1_idx, 1) : wrap_idx(w_w0_idx, 1);
        else
            r_rr_ptr <= r_rr_ptr;
    end
    assign w_start = r_rr_ptr;
`endif

    // Winner search, stall decision, grants and slot next-state.
    always_comb begin
        w_w0_found    = 1'b0;
        w_w1_found    = 1'b0;
        w_w0_idx      = {IDX_W{1'b0}};
        w_w1_idx      = {IDX_W{1'b0}};
        w_idx         = {IDX_W{1'b0}};
        req_ready     = {NUM_REQ{1'b0}};
        w_state_a_nxt = r_state_a;
        w_state_b_nxt = r_state_b;
        w_rsp_nxt     = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = wrap_idx(w_start, k);
            if (req_valid[w_idx]) begin
                if (!w_w0_found) begin
                    w_w0_found = 1'b1;
                    w_w0_idx   = w_idx;
                end else if (!w_w1_found &&
                             !conflict(req_addr[w_w0_idx*ADDR_W +: ADDR_W], req_we[w_w0_idx],
                                       req_addr[w_idx*ADDR_W +: ADDR_W], req_we[w_idx])) begin
                    w_w1_found = 1'b1;
                    w_w1_idx   = w_idx;
                end else begin
                end
            end else begin
            end
        end
        // A slot can take a new command only if it is empty or draining this cycle.
        w_slot_free = ((r_state_a == SLOT_EMPTY) || ready_a) &&
                      ((r_state_b == SLOT_EMPTY) || ready_b);
        w_grant_a   = w_slot_free && w_w0_found;
        w_grant_b   = w_slot_free && w_w1_found;
        if (w_grant_a) req_ready[w_w0_idx] = 1'b1;
        else           req_ready = req_ready;
        if (w_grant_b) req_ready[w_w1_idx] = 1'b1;
        else           req_ready = req_ready;

        case (r_state_a)
            SLOT_EMPTY: w_state_a_nxt = w_grant_a ? SLOT_PEND : SLOT_EMPTY;
            SLOT_PEND:  w_state_a_nxt = (w_grant_a || !ready_a) ? SLOT_PEND : SLOT_EMPTY;
            default:    w_state_a_nxt = SLOT_EMPTY;
        endcase
        case (r_state_b)
            SLOT_EMPTY: w_state_b_nxt = w_grant_b ? SLOT_PEND : SLOT_EMPTY;
            SLOT_PEND:  w_state_b_nxt = (w_grant_b || !ready_b) ? SLOT_PEND : SLOT_EMPTY;
            default:    w_state_b_nxt = SLOT_EMPTY;
        endcase

        w_acc_rd_a = (r_state_a == SLOT_PEND) && ready_a && !r_we_a;
        w_acc_rd_b = (r_state_b == SLOT_PEND) && ready_b && !r_we_b;
        if (w_acc_rd_a) w_rsp_nxt[r_tag_a] = 1'b1;
        else            w_rsp_nxt = w_rsp_nxt;
        if (w_acc_rd_b) w_rsp_nxt[r_tag_b] = 1'b1;
        else            w_rsp_nxt = w_rsp_nxt;
    end

    // Slot command registers and read-return tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_a   <= SLOT_EMPTY;
            r_state_b   <= SLOT_EMPTY;
            r_we_a      <= 1'b0;
            r_we_b      <= 1'b0;
            r_addr_a    <= {ADDR_W{1'b0}};
            r_addr_b    <= {ADDR_W{1'b0}};
            r_data_a    <= {DATA_W{1'b0}};
            r_data_b    <= {DATA_W{1'b0}};
            r_tag_a     <= {IDX_W{1'b0}};
            r_tag_b     <= {IDX_W{1'b0}};
            r_ret_a     <= 1'b0;
            r_ret_b     <= 1'b0;
            r_rsp_valid <= {NUM_REQ{1'b0}};
        end else begin
            r_state_a   <= w_state_a_nxt;
            r_state_b   <= w_state_b_nxt;
            r_ret_a     <= w_acc_rd_a;
            r_ret_b     <= w_acc_rd_b;
            r_rsp_valid <= w_rsp_nxt;
            if (w_grant_a) begin
                r_we_a   <= req_we[w_w0_idx];
                r_addr_a <= req_addr[w_w0_idx*ADDR_W +: ADDR_W];
                r_data_a <= req_wdata[w_w0_idx*DATA_W +: DATA_W];
                r_tag_a  <= w_w0_idx;
            end
            if (w_grant_b) begin
                r_we_b   <= req_we[w_w1_idx];
                r_addr_b <= req_addr[w_w1_idx*ADDR_W +: ADDR_W];
                r_data_b <= req_wdata[w_w1_idx*DATA_W +: DATA_W];
                r_tag_b  <= w_w1_idx;
            end
        end
    end

    assign valid_a    = (r_state_a == SLOT_PEND);
    assign valid_b    = (r_state_b == SLOT_PEND);
    assign we_a       = r_we_a;
    assign we_b       = r_we_b;
    assign addr_a     = r_addr_a;
    assign addr_b     = r_addr_b;
    assign data_a     = r_data_a;
    assign data_b     = r_data_b;
    assign rsp_valid  = r_rsp_valid;
    // Read data comes straight from the RAM and is zeroed when no read returns on that lane.
    assign rsp_data   = r_ret_a ? q_a : {DATA_W{1'b0}};
    assign rsp_data_b = r_ret_b ? q_b : {DATA_W{1'b0}};
endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter: grant-pattern vector table plus read-return, stall and reset sequences.
module tb_dpram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_we, req_ready, rsp_valid;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  rsp_data, rsp_data_b, data_a, data_b, q_a, q_b;
    logic        valid_a, valid_b, we_a, we_b, ready_a, ready_b;
    logic [5:0]  addr_a, addr_b;
    logic [7:0]  mem [64];
    int          n_tests = 0;
    int          n_fail  = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_ready;
        logic        exp_va;
        logic        exp_vb;
        logic        exp_wea;
        logic [5:0]  exp_aa;
        logic [5:0]  exp_ab;
    } vec_t;
    vec_t tbl [10];

    dpram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_data_b(rsp_data_b),
        .valid_a(valid_a), .valid_b(valid_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
        .ready_a(ready_a), .ready_b(ready_b), .q_a(q_a), .q_b(q_b)
    );

    always #5 clk = ~clk;

    // Synchronous-read dual-port RAM model.
    always @(posedge clk) begin
        if (valid_a && ready_a) begin
            if (we_a) mem[addr_a] <= data_a;
            else      q_a <= mem[addr_a];
        end
        if (valid_b && ready_b) begin
            if (we_b) mem[addr_b] <= data_b;
            else      q_b <= mem[addr_b];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic [23:0] a, input logic [31:0] d);
        req_valid = v;
        req_we    = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        tbl[0] = '{4'b1111, 4'b0000, {6'h03, 6'h02, 6'h01, 6'h00}, 32'h0, 4'b0011, 1'b1, 1'b1, 1'b0, 6'h00, 6'h01};
        tbl[1] = '{4'b1111, 4'b0000, {6'h03, 6'h02, 6'h01, 6'h00}, 32'h0, 4'b1100, 1'b1, 1'b1, 1'b0, 6'h02, 6'h03};
        tbl[2] = '{4'b0111, 4'b0001, {6'h00, 6'h20, 6'h10, 6'h10}, 32'h0000005A, 4'b0101, 1'b1, 1'b1, 1'b1, 6'h10, 6'h20};
        tbl[3] = '{4'b0010, 4'b0000, {6'h00, 6'h00, 6'h10, 6'h00}, 32'h0, 4'b0010, 1'b1, 1'b0, 1'b0, 6'h10, 6'h00};
        tbl[4] = '{4'b1100, 4'b1100, {6'h07, 6'h07, 6'h00, 6'h00}, 32'h00770000, 4'b0100, 1'b1, 1'b0, 1'b1, 6'h07, 6'h00};
        tbl[5] = '{4'b1001, 4'b0000, {6'h07, 6'h00, 6'h00, 6'h07}, 32'h0, 4'b1001, 1'b1, 1'b1, 1'b0, 6'h07, 6'h07};
        tbl[6] = '{4'b0000, 4'b0000, 24'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00};
        tbl[7] = '{4'b1111, 4'b0000, {6'h03, 6'h02, 6'h01, 6'h00}, 32'h0, 4'b0110, 1'b1, 1'b1, 1'b0, 6'h01, 6'h02};
        tbl[8] = '{4'b1111, 4'b0000, {6'h03, 6'h02, 6'h01, 6'h00}, 32'h0, 4'b1001, 1'b1, 1'b1, 1'b0, 6'h03, 6'h00};
        tbl[9] = '{4'b0110, 4'b0100, {6'h00, 6'h09, 6'h09, 6'h00}, 32'h0, 4'b0010, 1'b1, 1'b0, 1'b0, 6'h09, 6'h00};

        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        q_a = 8'h00; q_b = 8'h00;
        rst_n = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        drive(4'b0000, 4'b0000, 24'h0, 32'h0);

        // Reset state
        step(); step();
        req_valid = 4'b0100;
        @(negedge clk);
        check("rst_valid_a", {31'h0, valid_a}, 32'h0);
        check("rst_valid_b", {31'h0, valid_b}, 32'h0);
        check("rst_we_a", {31'h0, we_a}, 32'h0);
        check("rst_addr_a", {26'h0, addr_a}, 32'h0);
        check("rst_addr_b", {26'h0, addr_b}, 32'h0);
        check("rst_data_a", {24'h0, data_a}, 32'h0);
        check("rst_rsp_valid", {28'h0, rsp_valid}, 32'h0);
        check("rst_rsp_data", {24'h0, rsp_data}, 32'h0);
        check("rst_rsp_data_b", {24'h0, rsp_data_b}, 32'h0);
        check("rst_req_ready", {28'h0, req_ready}, 32'h4);
        step();
        req_valid = 4'b0000;
        rst_n = 1'b1;

        // Grant-pattern table, one cycle per vector, RAM always ready
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].valid, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), {28'h0, req_ready}, {28'h0, tbl[i].exp_ready});
            step();
            drive(4'b0000, 4'b0000, 24'h0, 32'h0);
            check($sformatf("vec%0d_valid_a", i), {31'h0, valid_a}, {31'h0, tbl[i].exp_va});
            check($sformatf("vec%0d_valid_b", i), {31'h0, valid_b}, {31'h0, tbl[i].exp_vb});
            if (tbl[i].exp_va) begin
                check($sformatf("vec%0d_addr_a", i), {26'h0, addr_a}, {26'h0, tbl[i].exp_aa});
                check($sformatf("vec%0d_we_a", i), {31'h0, we_a}, {31'h0, tbl[i].exp_wea});
            end
            if (tbl[i].exp_vb)
                check($sformatf("vec%0d_addr_b", i), {26'h0, addr_b}, {26'h0, tbl[i].exp_ab});
        end

        // Single request: write 0xA5 to 0x05, then read it back with 2-edge latency
        drive(4'b0010, 4'b0010, {6'h00, 6'h00, 6'h05, 6'h00}, 32'h0000A500);
        @(negedge clk);
        check("single_wr_ready", {28'h0, req_ready}, 32'h2);
        step();
        drive(4'b0010, 4'b0000, {6'h00, 6'h00, 6'h05, 6'h00}, 32'h0);
        @(negedge clk);
        check("single_rd_ready", {28'h0, req_ready}, 32'h2);
        step();
        drive(4'b0000, 4'b0000, 24'h0, 32'h0);
        @(negedge clk);
        check("single_rsp_early", {28'h0, rsp_valid}, 32'h0);
        step();
        @(negedge clk);
        check("single_rsp_valid", {28'h0, rsp_valid}, 32'h2);
        check("single_rsp_data", {24'h0, rsp_data}, 32'hA5);

        // Dual return: seed 0x01=0x11 and 0x02=0x22, then req2/req3 read together
        step();
        drive(4'b0011, 4'b0011, {6'h00, 6'h00, 6'h02, 6'h01}, 32'h00002211);
        @(negedge clk);
        check("dual_wr_ready", {28'h0, req_ready}, 32'h3);
        step();
        drive(4'b1100, 4'b0000, {6'h02, 6'h01, 6'h00, 6'h00}, 32'h0);
        @(negedge clk);
        check("dual_rd_ready", {28'h0, req_ready}, 32'hC);
        step();
        drive(4'b0000, 4'b0000, 24'h0, 32'h0);
        @(negedge clk);
        check("dual_rsp_early", {28'h0, rsp_valid}, 32'h0);
        step();
        @(negedge clk);
        check("dual_rsp_valid", {28'h0, rsp_valid}, 32'hC);
        check("dual_rsp_data", {24'h0, rsp_data}, 32'h11);
        check("dual_rsp_data_b", {24'h0, rsp_data_b}, 32'h22);

        // Back-pressure: port B read of 0x10 (written 0x5A by vec2) stalled 3 cycles
        step();
        drive(4'b0011, 4'b0000, {6'h00, 6'h00, 6'h10, 6'h01}, 32'h0);
        @(negedge clk);
        check("bp_ready", {28'h0, req_ready}, 32'h3);
        step();
        drive(4'b0100, 4'b0000, {6'h00, 6'h03, 6'h00, 6'h00}, 32'h0);
        ready_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_stall%0d_ready", i), {28'h0, req_ready}, 32'h0);
            check($sformatf("bp_stall%0d_valid_b", i), {31'h0, valid_b}, 32'h1);
            check($sformatf("bp_stall%0d_addr_b", i), {26'h0, addr_b}, 32'h10);
            if (i == 1) begin
                check("bp_rsp_a_valid", {28'h0, rsp_valid}, 32'h1);
                check("bp_rsp_a_data", {24'h0, rsp_data}, 32'h11);
            end
            step();
        end
        ready_b = 1'b1;
        drive(4'b0000, 4'b0000, 24'h0, 32'h0);
        @(negedge clk);
        check("bp_rsp_none", {28'h0, rsp_valid}, 32'h0);
        check("bp_valid_b_held", {31'h0, valid_b}, 32'h1);
        step();
        @(negedge clk);
        check("bp_rsp_b_valid", {28'h0, rsp_valid}, 32'h2);
        check("bp_rsp_b_data", {24'h0, rsp_data_b}, 32'h5A);
        check("bp_rsp_a_quiet", {24'h0, rsp_data}, 32'h0);

        // Reset one cycle after a read is accepted
        step();
        drive(4'b1000, 4'b0000, {6'h02, 6'h00, 6'h00, 6'h00}, 32'h0);
        @(negedge clk);
        check("rm_ready", {28'h0, req_ready}, 32'h8);
        step();
        drive(4'b0000, 4'b0000, 24'h0, 32'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rm_rsp_valid", {28'h0, rsp_valid}, 32'h0);
        check("rm_valid_a", {31'h0, valid_a}, 32'h0);
        check("rm_addr_a", {26'h0, addr_a}, 32'h0);
        check("rm_rsp_data", {24'h0, rsp_data}, 32'h0);
        step();
        @(negedge clk);
        check("rm_rsp_late", {28'h0, rsp_valid}, 32'h0);
        step();
        drive(4'b0110, 4'b0000, {6'h00, 6'h02, 6'h01, 6'h00}, 32'h0);
        @(negedge clk);
        check("rm_post_ready", {28'h0, req_ready}, 32'h6);
        step();
        drive(4'b0000, 4'b0000, 24'h0, 32'h0);
        step();
        @(negedge clk);
        check("rm_post_rsp_valid", {28'h0, rsp_valid}, 32'h6);
        check("rm_post_rsp_data", {24'h0, rsp_data}, 32'h11);
        check("rm_post_rsp_data_b", {24'h0, rsp_data_b}, 32'h22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
